// File: rtl/nios_irq_aggregator.sv
// nios_irq_aggregator
//   Collects up to 16 peripheral interrupt lines for a Nios II CPU. Each raw
//   line is synchronised to clk, latched as either a level or a rising edge,
//   masked, and OR-combined into one registered irq to the CPU. Software sees
//   the state through a small Avalon-MM register file and clears edge events
//   with write-1-to-clear.
//
//   Word map: 0 PENDING (W1C), 1 MASK, 2 EDGE_SEL, 3 RAW, 4 ACTIVE (W1 = soft
//   set), 5 HIGHEST {any, 11'b0, idx}, 6/7 read zero.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   address[2:0]          Avalon word address
//   chipselect, write_n   Avalon select and active-low write strobe
//   writedata[15:0]       Avalon write data
//   readdata[15:0]        registered read data, one clock after address
//   irq_in[NUM_IRQ-1:0]   raw active-high interrupt sources
//   irq_out               registered combined interrupt to the CPU
module nios_irq_aggregator #(
  parameter int          NUM_IRQ     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] RESET_EDGE  = 16'h0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_RAW     = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
  localparam logic [2:0] ADDR_HIGHEST = 3'd5;

  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] s_dly_q, s_dly_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [15:0]        rd_q, rd_d;
  logic               irq_q, irq_d;

  logic               wr;
  logic [NUM_IRQ-1:0] wd;
  logic [NUM_IRQ-1:0] clr_wr, set_wr, rise, active;
  logic [3:0]         hi_idx;
  logic               unused_wdata;

  // Synchroniser chain; depth 0 means irq_in is already in the clk domain.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = irq_in;
    end else begin : g_sync
      logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
      logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = irq_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_d[k] = sync_q[k-1];
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
          end
        end else begin
          sync_q <= sync_d;
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Writedata bits above NUM_IRQ are deliberately dropped.
  assign unused_wdata = &{1'b0, writedata};

  assign wr     = chipselect & ~write_n;
  assign wd     = writedata[NUM_IRQ-1:0];
  assign clr_wr = (wr && address == ADDR_PENDING) ? wd : '0;
  assign set_wr = (wr && address == ADDR_ACTIVE)  ? wd : '0;
  // s_dly runs in every mode so switching a bit to edge mode never fakes a rise.
  assign rise   = s & ~s_dly_q;
  assign active = pend_q & mask_q;

  always_comb begin
    s_dly_d = s;
    mask_d  = mask_q;
    edge_d  = edge_q;
    pend_d  = pend_q;
    if (wr && address == ADDR_MASK) mask_d = wd;
    if (wr && address == ADDR_EDGE) edge_d = wd;

    // Edge bits: a new event or soft set beats a same-cycle W1C so no event is lost.
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (edge_q[i]) pend_d[i] = rise[i] | set_wr[i] | (pend_q[i] & ~clr_wr[i]);
      else           pend_d[i] = s[i];
    end

    irq_d = |active;

    // Scan downwards so the lowest-numbered active source wins.
    hi_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) hi_idx = 4'(i);
    end

    rd_d = '0;
    case (address)
      ADDR_PENDING: rd_d[NUM_IRQ-1:0] = pend_q;
      ADDR_MASK:    rd_d[NUM_IRQ-1:0] = mask_q;
      ADDR_EDGE:    rd_d[NUM_IRQ-1:0] = edge_q;
      ADDR_RAW:     rd_d[NUM_IRQ-1:0] = s;
      ADDR_ACTIVE:  rd_d[NUM_IRQ-1:0] = active;
      ADDR_HIGHEST: rd_d = {irq_d, 11'b0, hi_idx};
      default:      rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_dly_q <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      edge_q  <= RESET_EDGE[NUM_IRQ-1:0];
      rd_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      s_dly_q <= s_dly_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      rd_q    <= rd_d;
      irq_q   <= irq_d;
    end
  end

  assign readdata = rd_q;
  assign irq_out  = irq_q;

endmodule
